onchip_ram_dp_pipelined: RTL
============================

Name: onchip_ram_dp_pipelined

Overview:
- Parametrised single-clock, true dual-port on-chip RAM with two Avalon-MM slaves (s1: unsuffixed ports, s2: "2"-suffixed ports).
- Successor to the fixed 32-bit, 393216-word combinational-read RAM. Adds configurable width/depth, pipelined reads with readdatavalid, waitrequest, a hardware zero-fill engine, deterministic write-collision resolution and out-of-range handling.
- Sits between the Nios CPU data/instruction masters and the Ethernet DMA on the shared system bus.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; byte lanes NB = DATA_WIDTH/8.
- DEPTH, 393216, number of words.
- ADDR_WIDTH, 19, address bits; requires 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill engine after reset; 0 = start in RUN.
- INIT_FILE, "Nios_CPU_qsys_onchip_ram.hex", initial contents when CLEAR_ON_RESET=0.

Ports:
- clk  in  1  single clock for both slaves.
- reset  in  1  asynchronous, active-high.
- address / address2  in  ADDR_WIDTH  word address, s1 / s2.
- byteenable / byteenable2  in  NB  byte lane enables.
- chipselect / chipselect2  in  1  slave select.
- read / read2  in  1  read request.
- write / write2  in  1  write request.
- writedata / writedata2  in  DATA_WIDTH  write data.
- readdata / readdata2  out  DATA_WIDTH  read data.
- readdatavalid / readdatavalid2  out  1  one-cycle read-data strobe.
- waitrequest / waitrequest2  out  1  stall; high during CLEAR.
- clear_req  in  1  single-cycle pulse; restarts zero-fill from RUN.
- init_done  out  1  high in RUN.
- collision  out  1  one-cycle pulse on a same-address dual write.

Behaviour:
- Reset values:
  - readdata/readdata2 = 0; readdatavalid/readdatavalid2 = 0; collision = 0.
  - Read pipelines flushed. Memory contents are not reset.
  - CLEAR_ON_RESET=1: waitrequest/waitrequest2 = 1, init_done = 0, state CLEAR, fill counter = 0.
  - CLEAR_ON_RESET=0: waitrequest/waitrequest2 = 0, init_done = 1, state RUN.
- FSM CLEAR:
  - Each cycle writes all-zero data to mem[counter] and increments counter.
  - After the cycle that writes DEPTH-1, moves to RUN on the next edge. Total CLEAR duration is exactly DEPTH cycles.
  - Both waitrequests are held at 1 and no transfers are accepted.
- FSM RUN:
  - waitrequest = waitrequest2 = 0; init_done = 1.
  - clear_req = 1 moves to CLEAR (counter = 0) on the next edge. clear_req is ignored while in CLEAR.
  - Reads accepted before the transition still deliver readdatavalid on schedule, returning pre-clear data.
- Accept:
  - A port transfer is accepted when chipselect & (read | write) & ~waitrequest.
  - If read and write are both high, it is a write only; no readdatavalid is produced.
- Write: only lanes with byteenable = 1 are updated, at the accept edge.
- Read:
  - readdata is presented and readdatavalid pulses exactly READ_LATENCY cycles after the accept edge.
  - Back-to-back reads give one valid per cycle.
  - readdata holds its last value between valids.
- Read-during-write, same address (same or opposite port): the read returns OLD data.
- Dual-write collision: both ports write the same in-range address in the same cycle.
  - For overlapping byte lanes, s1 data wins and s2 data is dropped.
  - s2-only lanes are written normally.
  - collision pulses for 1 cycle, aligned to the edge after the accept.
- Out of range (address >= DEPTH):
  - Writes are ignored.
  - Reads return 0 with normal readdatavalid timing.
- Asynchronous reset mid-operation:
  - In-flight reads are dropped and no readdatavalid is issued.
  - A partial CLEAR restarts from 0 when CLEAR_ON_RESET=1.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1; release reset -> waitrequest = 1 for exactly 16 cycles, then init_done = 1; a read of any address returns 0x00000000.
- READ_LATENCY=2; s1 writes 0xDEADBEEF to addr 5, then s2 reads addr 5 in back-to-back cycles -> readdatavalid2 on cycles +2 and +3, both returning 0xDEADBEEF.
- s1 writes 0x11223344 with be=4'b0011, s2 writes 0xAABBCCDD with be=4'b0110, same cycle, addr 3, prior contents 0 -> mem[3] = 0x00BB3344; collision pulses once.
- s1 reads addr 7 (holding 0x5) while s2 writes 0x9 to addr 7 in the same cycle -> s1 gets 0x5; a re-read gets 0x9.
- DEPTH=12 with ADDR_WIDTH=4: write 0xFFFFFFFF to addr 13, then read addr 13 -> readdata 0, readdatavalid asserted; mem[13 mod 12] unchanged.
- clear_req pulsed 1 cycle after accepting a READ_LATENCY=2 read of addr 2 (holding 0x7) -> readdatavalid returns 0x7, waitrequest high 16 cycles, then addr 2 reads 0; assert reset mid-CLEAR -> readdatavalid = 0 immediately and fill restarts for 16 cycles.

Source files
------------

// File: rtl/onchip_ram_dp_pipelined.sv
// True dual-port on-chip RAM, two Avalon-MM slaves on one clock, with pipelined
// reads, a zero-fill engine, s1-priority write-collision merge and out-of-range masking.
module onchip_ram_dp_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 393216,
  parameter int ADDR_WIDTH     = 19,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  // Preload is applied by the device memory-initialisation flow, not by RTL.
  parameter     INIT_FILE      = "Nios_CPU_qsys_onchip_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    waitrequest2,
  input  logic                    clear_req,
  output logic                    init_done,
  output logic                    collision
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = (READ_LATENCY >= 2) ? 2 : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  w_clearing;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Index 0 is s1, index 1 is s2.
  logic [1:0][ADDR_WIDTH-1:0] w_addr;
  logic [1:0][NB-1:0]         w_be;
  logic [1:0][DATA_WIDTH-1:0] w_wdata;
  logic [1:0]                 w_cs, w_rd_req, w_wr_req, w_inr, w_acc, w_wr, w_rd;
  logic                       w_coll;

  logic [1:0][L-1:0]                 r_vld_pipe;
  logic [1:0][L-1:0][DATA_WIDTH-1:0] r_rd_pipe;
  logic                              r_collision;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clearing  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clearing = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  assign w_addr   = {address2, address};
  assign w_be     = {byteenable2, byteenable};
  assign w_wdata  = {writedata2, writedata};
  assign w_cs     = {chipselect2, chipselect};
  assign w_rd_req = {read2, read};
  assign w_wr_req = {write2, write};

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign w_inr[p] = ({1'b0, w_addr[p]} < DEPTH_W);
  end

  // Read+write together is a write; out-of-range writes are accepted but dropped.
  assign w_acc  = w_cs & (w_rd_req | w_wr_req) & {2{~w_clearing}};
  assign w_wr   = w_acc & w_wr_req & w_inr;
  assign w_rd   = w_acc & w_rd_req & ~w_wr_req;
  assign w_coll = w_wr[0] & w_wr[1] & (w_addr[0] == w_addr[1]);

  // s2 is applied first so s1 overrides it on shared byte lanes.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--)
        if (w_wr[p])
          for (int b = 0; b < NB; b++)
            if (w_be[p][b]) r_mem[w_addr[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
    end
  end

  // Non-blocking capture returns pre-write data on read-during-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_rd_pipe   <= '0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_coll;
      for (int p = 0; p < 2; p++) begin
        r_vld_pipe[p][0] <= w_rd[p];
        if (w_rd[p]) r_rd_pipe[p][0] <= w_inr[p] ? r_mem[w_addr[p]] : '0;
        for (int s = 1; s < L; s++) begin
          r_vld_pipe[p][s] <= r_vld_pipe[p][s-1];
          if (r_vld_pipe[p][s-1]) r_rd_pipe[p][s] <= r_rd_pipe[p][s-1];
        end
      end
    end
  end

  assign readdata       = r_rd_pipe[0][L-1];
  assign readdata2      = r_rd_pipe[1][L-1];
  assign readdatavalid  = r_vld_pipe[0][L-1];
  assign readdatavalid2 = r_vld_pipe[1][L-1];
  assign waitrequest    = (r_state == S_CLEAR);
  assign waitrequest2   = (r_state == S_CLEAR);
  assign init_done      = (r_state == S_RUN);
  assign collision      = r_collision;
endmodule
